lsu_ctrl: RTL and testbench

Load/store sequencer for the MEM stage of the pipelined RISC-V core. It drives the data-memory request handshake, builds byte enables and store-data lanes, and stalls the pipeline until memory answers. It aligns and sign- or zero-extends returned load data. Its load_data output is the d_data_read value consumed by the writeback mux.

---
 rtl/lsu_ctrl_pkg.sv | 39 +++
 rtl/lsu_load_extract.sv | 46 ++++
 rtl/lsu_ctrl.sv | 146 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// ============================================================================
// Module  : lsu_ctrl_pkg
// Purpose : Shared opcode/funct3 constants, FSM states and alignment helper
//           for the MEM-stage load/store sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_ctrl_pkg;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Undefined funct3 encodings are treated as word accesses.
  function automatic logic f_aligned(input logic       is_load,
                                     input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic is_byte;
    logic is_half;
    is_byte = is_load ? (f3 == F3_B || f3 == F3_BU) : (f3 == F3_B);
    is_half = is_load ? (f3 == F3_H || f3 == F3_HU) : (f3 == F3_H);
    if (is_byte)      return 1'b1;
    else if (is_half) return ~lo[0];
    else              return (lo == 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_extract.sv
// ============================================================================
// Module  : lsu_load_extract
// Purpose : Selects the addressed byte/half/word of a memory read word and
//           sign- or zero-extends it to 32 bits.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_extract
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_raw[7:0];
    case (i_lane)
      2'd0:    w_byte = i_raw[7:0];
      2'd1:    w_byte = i_raw[15:8];
      2'd2:    w_byte = i_raw[23:16];
      default: w_byte = i_raw[31:24];
    endcase
    w_half = i_lane[1] ? i_raw[31:16] : i_raw[15:0];
  end

  always_comb begin
    o_data = i_raw;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0, w_half};
      F3_W:    o_data = i_raw;
      default: o_data = i_raw;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module  : lsu_ctrl
// Purpose : MEM-stage load/store sequencer: request handshake, store lanes,
//           pipeline stall, timeout abort and load data alignment.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_mem_valid,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_d_address,
  output logic [31:0] o_d_data_write,
  output logic [3:0]  o_d_byte_enable,
  output logic        o_d_write_enable,
  output logic        o_d_req,
  input  logic        i_d_ack,
  input  logic [31:0] i_d_data_raw,
  output logic [31:0] o_load_data,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [1:0]       r_state;
  logic [31:0]      r_addr;
  logic [2:0]       r_funct3;
  logic             r_store;
  logic [31:0]      r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_load_data;
  logic             r_timeout;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_memop;
  logic        w_aligned;
  logic        w_in_req;
  logic        w_abort;
  logic [31:0] w_ld_ext;
  logic [31:0] w_wdata;
  logic [3:0]  w_store_be;

  assign w_is_load  = (i_opcode == LOAD);
  assign w_is_store = (i_opcode == STORE);
  assign w_memop    = i_mem_valid & (w_is_load | w_is_store);
  assign w_aligned  = f_aligned(w_is_load, i_funct3, i_addr[1:0]);
  assign w_in_req   = (r_state == S_REQ);
  assign w_abort    = (TIMEOUT_CYCLES > 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_wdata = i_store_data;
    case (i_funct3)
      F3_B:    w_wdata = {4{i_store_data[7:0]}};
      F3_H:    w_wdata = {2{i_store_data[15:0]}};
      default: w_wdata = i_store_data;
    endcase
  end

  always_comb begin
    w_store_be = 4'b1111;
    case (r_funct3)
      F3_B:    w_store_be = 4'b0001 << r_addr[1:0];
      F3_H:    w_store_be = 4'b0011 << r_addr[1:0];
      default: w_store_be = 4'b1111;
    endcase
  end

  lsu_load_extract u_extract (
    .i_raw    (i_d_data_raw),
    .i_funct3 (r_funct3),
    .i_lane   (r_addr[1:0]),
    .o_data   (w_ld_ext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_funct3    <= '0;
      r_store     <= 1'b0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_load_data <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_memop) begin
            if (w_aligned) begin
              r_addr   <= i_addr;
              r_funct3 <= i_funct3;
              r_store  <= w_is_store;
              if (w_is_store) r_wdata <= w_wdata;
              r_state  <= S_REQ;
            end else begin
              r_load_data <= '0;
            end
          end
        end
        S_REQ: begin
          // A late ack in the abort cycle still completes the access.
          if (i_d_ack) begin
            if (!r_store) r_load_data <= w_ld_ext;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else if (w_abort) begin
            r_load_data <= '0;
            r_timeout   <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_d_address      = {r_addr[31:2], 2'b00};
  assign o_d_data_write   = r_wdata;
  assign o_d_byte_enable  = w_in_req ? (r_store ? w_store_be : 4'b1111) : 4'b0000;
  assign o_d_write_enable = w_in_req & r_store;
  assign o_d_req          = w_in_req;
  assign o_load_data      = r_load_data;
  assign o_stall          = w_in_req | ((r_state == S_IDLE) & w_memop & w_aligned);
  assign o_misaligned     = (r_state == S_IDLE) & w_memop & ~w_aligned;
  assign o_timeout        = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module  : tb_lsu_ctrl
// Purpose : Self-checking bench for lsu_ctrl against a behavioural model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

  localparam int         TO    = 4;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_AL = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_mem_valid = 1'b0;
  logic [6:0]  i_opcode = '0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_store_data = '0;
  logic        i_d_ack = 1'b0;
  logic [31:0] i_d_data_raw = '0;
  logic [31:0] o_d_address;
  logic [31:0] o_d_data_write;
  logic [3:0]  o_d_byte_enable;
  logic        o_d_write_enable;
  logic        o_d_req;
  logic [31:0] o_load_data;
  logic        o_stall;
  logic        o_misaligned;
  logic        o_timeout;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_load = '0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_mem_valid      (i_mem_valid),
    .i_opcode         (i_opcode),
    .i_funct3         (i_funct3),
    .i_addr           (i_addr),
    .i_store_data     (i_store_data),
    .o_d_address      (o_d_address),
    .o_d_data_write   (o_d_data_write),
    .o_d_byte_enable  (o_d_byte_enable),
    .o_d_write_enable (o_d_write_enable),
    .o_d_req          (o_d_req),
    .i_d_ack          (i_d_ack),
    .i_d_data_raw     (i_d_data_raw),
    .o_load_data      (o_load_data),
    .o_stall          (o_stall),
    .o_misaligned     (o_misaligned),
    .o_timeout        (o_timeout)
  );

  // Access size in bytes from the instruction kind and funct3.
  function automatic int acc_size(input bit is_ld, input logic [2:0] f3);
    if (is_ld) begin
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
    end
    if (f3 == 3'd0) return 1;
    if (f3 == 3'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lane,
                                           input logic [31:0] raw);
    logic [31:0] b;
    logic [31:0] h;
    b = (raw >> (8 * lane)) & 32'hFF;
    h = (raw >> (16 * (lane / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return raw;
    endcase
  endfunction

  // Drives one instruction through the block and checks every cycle of it.
  task automatic run_access(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd, input int ack_dly,
                            input logic [31:0] raw, input bit late_ack);
    bit          is_ld;
    bit          al;
    bit          to;
    int          sz;
    int          lane;
    int          n;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_adr;
    is_ld = (op == OP_LD);
    sz    = acc_size(is_ld, f3);
    lane  = int'(a % 4);
    al    = (lane % sz) == 0;
    e_adr = a - (a % 4);
    if (!is_ld) begin
      e_be = (sz == 1) ? 4'(1 << lane) : (sz == 2) ? 4'(3 << lane) : 4'hF;
      e_wd = (sz == 1) ? (sd % 256) * 32'h01010101 :
             (sz == 2) ? (sd % 65536) * 32'h00010001 : sd;
    end else begin
      e_be = 4'hF;
      e_wd = 32'h0;
    end

    @(negedge clk);
    i_mem_valid = 1'b1; i_opcode = op; i_funct3 = f3; i_addr = a; i_store_data = sd;
    i_d_ack = 1'b0;
    #1;
    checks++; if (o_stall !== al) begin errors++;
      $display("FAIL %s accept stall got=%b exp=%b", tag, o_stall, al); end
    checks++; if (o_misaligned !== !al) begin errors++;
      $display("FAIL %s misaligned got=%b exp=%b", tag, o_misaligned, !al); end
    checks++; if (o_d_req !== 1'b0) begin errors++;
      $display("FAIL %s accept d_req got=%b exp=0", tag, o_d_req); end

    if (!al) begin
      m_load = 32'h0;
      @(negedge clk);
      i_mem_valid = 1'b0;
      #1;
      checks++; if (o_load_data !== m_load) begin errors++;
        $display("FAIL %s misaligned load_data got=%h exp=%h", tag, o_load_data, m_load); end
      checks++; if (o_d_req !== 1'b0 || o_stall !== 1'b0 || o_misaligned !== 1'b0) begin
        errors++;
        $display("FAIL %s after misaligned req/stall/mis got=%b%b%b exp=000",
                 tag, o_d_req, o_stall, o_misaligned); end
      return;
    end

    to = ack_dly > TO;
    n  = to ? TO : ack_dly;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      i_d_ack      = (k == ack_dly);
      i_d_data_raw = (k == ack_dly) ? raw : $urandom;
      #1;
      checks++; if (o_d_req !== 1'b1 || o_stall !== 1'b1) begin errors++;
        $display("FAIL %s req%0d req/stall got=%b%b exp=11", tag, k, o_d_req, o_stall); end
      checks++; if (o_d_address !== e_adr) begin errors++;
        $display("FAIL %s req%0d d_address got=%h exp=%h", tag, k, o_d_address, e_adr); end
      checks++; if (o_d_byte_enable !== e_be) begin errors++;
        $display("FAIL %s req%0d byte_enable got=%b exp=%b", tag, k, o_d_byte_enable, e_be); end
      checks++; if (o_d_write_enable !== !is_ld) begin errors++;
        $display("FAIL %s req%0d write_enable got=%b exp=%b", tag, k, o_d_write_enable, !is_ld); end
      if (!is_ld) begin
        checks++; if (o_d_data_write !== e_wd) begin errors++;
          $display("FAIL %s req%0d data_write got=%h exp=%h", tag, k, o_d_data_write, e_wd); end
      end
    end

    if (to)         m_load = 32'h0;
    else if (is_ld) m_load = ref_load(f3, lane, raw);

    @(negedge clk);
    i_mem_valid  = 1'b0;
    i_d_ack      = late_ack;
    i_d_data_raw = $urandom;
    #1;
    checks++; if (o_d_req !== 1'b0 || o_stall !== 1'b0) begin errors++;
      $display("FAIL %s done req/stall got=%b%b exp=00", tag, o_d_req, o_stall); end
    checks++; if (o_timeout !== to) begin errors++;
      $display("FAIL %s done timeout got=%b exp=%b", tag, o_timeout, to); end
    checks++; if (o_d_byte_enable !== 4'h0 || o_d_write_enable !== 1'b0) begin errors++;
      $display("FAIL %s done be/we got=%b/%b exp=0000/0", tag, o_d_byte_enable,
               o_d_write_enable); end
    checks++; if (o_load_data !== m_load) begin errors++;
      $display("FAIL %s done load_data got=%h exp=%h", tag, o_load_data, m_load); end
    if (!is_ld) begin
      checks++; if (o_d_data_write !== e_wd) begin errors++;
        $display("FAIL %s done data_write hold got=%h exp=%h", tag, o_d_data_write, e_wd); end
    end

    @(negedge clk);
    #1;
    checks++; if (o_d_req !== 1'b0 || o_timeout !== 1'b0 || o_stall !== 1'b0) begin errors++;
      $display("FAIL %s idle req/timeout/stall got=%b%b%b exp=000", tag, o_d_req, o_timeout,
               o_stall); end
    checks++; if (o_load_data !== m_load) begin errors++;
      $display("FAIL %s idle load_data got=%h exp=%h", tag, o_load_data, m_load); end
    i_d_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({o_d_address, o_d_data_write, o_load_data} !== 96'h0) begin errors++;
      $display("FAIL reset data outputs got=%h/%h/%h exp=0", o_d_address, o_d_data_write,
               o_load_data); end
    checks++; if ({o_d_byte_enable, o_d_write_enable, o_d_req, o_stall, o_misaligned,
                   o_timeout} !== 9'h0) begin errors++;
      $display("FAIL reset control outputs got=%b%b%b%b%b%b exp=0", o_d_byte_enable,
               o_d_write_enable, o_d_req, o_stall, o_misaligned, o_timeout); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    run_access("lw",  OP_LD, 3'd2, 32'h100, 32'h0,      3, 32'hDEADBEEF, 1'b0);
    run_access("lb",  OP_LD, 3'd0, 32'h103, 32'h0,      1, 32'h80112233, 1'b0);
    run_access("lbu", OP_LD, 3'd4, 32'h103, 32'h0,      2, 32'h80112233, 1'b0);
    run_access("lhu", OP_LD, 3'd5, 32'h102, 32'h0,      1, 32'h80112233, 1'b0);
    run_access("sh",  OP_ST, 3'd1, 32'h202, 32'hABCD,   2, 32'h0,        1'b1);
    run_access("sb",  OP_ST, 3'd0, 32'h201, 32'h12345678, 4, 32'h0,      1'b0);
    run_access("lw_mis", OP_LD, 3'd2, 32'h101, 32'h0,   1, 32'h0,        1'b0);
  endtask

  task automatic test_timeout();
    run_access("lw_ok", OP_LD, 3'd2, 32'h500, 32'h0, 4, 32'h13579BDF, 1'b0);
    run_access("lw_to", OP_LD, 3'd2, 32'h504, 32'h0, 1000, 32'h0, 1'b1);
  endtask

  task automatic test_non_mem();
    logic [31:0] held;
    run_access("lw_pre", OP_LD, 3'd2, 32'h600, 32'h0, 1, 32'hCAFEF00D, 1'b0);
    held = m_load;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_mem_valid = (k != 2); i_opcode = (k == 2) ? OP_LD : OP_AL;
      i_funct3 = 3'd2; i_addr = 32'h700; i_d_ack = (k == 1);
      #1;
      checks++; if (o_stall !== 1'b0 || o_misaligned !== 1'b0 || o_d_req !== 1'b0) begin
        errors++;
        $display("FAIL nonmem%0d stall/mis/req got=%b%b%b exp=000", k, o_stall,
                 o_misaligned, o_d_req); end
    end
    @(negedge clk);
    i_mem_valid = 1'b0; i_d_ack = 1'b0;
    #1;
    checks++; if (o_d_req !== 1'b0 || o_load_data !== held) begin errors++;
      $display("FAIL nonmem after req=%b load_data got=%h exp=%h", o_d_req, o_load_data,
               held); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_mem_valid = 1'b1; i_opcode = OP_LD; i_funct3 = 3'd2; i_addr = 32'h300;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (o_d_req !== 1'b1) begin errors++;
      $display("FAIL rstmid pre d_req got=%b exp=1", o_d_req); end
    #1;
    reset_n = 1'b0; i_mem_valid = 1'b0;
    #1;
    m_load = 32'h0;
    checks++; if (o_d_req !== 1'b0 || o_stall !== 1'b0 || o_d_byte_enable !== 4'h0) begin
      errors++;
      $display("FAIL rstmid req/stall/be got=%b%b%b exp=000", o_d_req, o_stall,
               o_d_byte_enable); end
    checks++; if (o_load_data !== 32'h0 || o_d_address !== 32'h0) begin errors++;
      $display("FAIL rstmid load_data/addr got=%h/%h exp=0", o_load_data, o_d_address); end
    @(negedge clk);
    reset_n = 1'b1;
    run_access("sb_post", OP_ST, 3'd0, 32'h401, 32'h5A, 2, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [6:0]  op;
      logic [2:0]  f3;
      op = ($urandom_range(0, 1) == 1) ? OP_LD : OP_ST;
      f3 = 3'($urandom_range(0, 7));
      run_access($sformatf("rnd%0d", t), op, f3, $urandom, $urandom,
                 int'($urandom_range(1, 6)), $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_non_mem();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
